sprite_ram_loader: RTL and testbench
====================================

# sprite_ram_loader

Writable sprite store that accepts a stream of 24-bit RGB pixels and encodes each one to a 2-bit palette index. Encoded indices are written sequentially into a 441-entry (21×21) sprite buffer. A registered read port decodes indices back to 24-bit color for the renderer. The block sits between the sprite-upload path (host/DMA) and the VGA color mapper, and lets sprites be replaced at run time instead of baked into ROM.

## Interface
Parameters:
- DEPTH, 441, pixels per sprite (entries in buffer)
- ADDR_W, 9, address width; 2^ADDR_W ≥ DEPTH
- PAL0, 24'h800080, palette entry 0 (transparent key)
- PAL1, 24'h202020, palette entry 1
- PAL2, 24'hE45810, palette entry 2
- PAL3, 24'hF4D4B4, palette entry 3

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  begin a load pass (single-cycle pulse)
- pix_valid  in  1  pix_color holds a pixel
- pix_color  in  24  RGB pixel, 8:8:8
- pix_ready  out  1  block accepts pixel this cycle
- busy  out  1  load pass in progress
- done  out  1  one-cycle pulse after the last pixel is written
- err  out  1  sticky: an unmatched color was seen this pass
- pixel_count  out  ADDR_W  pixels accepted this pass
- read_address  in  ADDR_W  renderer read address
- output_color  out  24  decoded color, registered

## Operation
- FSM states:
  - IDLE: pix_ready=0, busy=0.
  - LOAD: pix_ready=1, busy=1.
  - DONE: one cycle, done=1, busy=0, pix_ready=0.
- Transitions:
  - IDLE → LOAD on start.
  - LOAD → DONE on the accept of pixel DEPTH-1.
  - DONE → IDLE unconditionally.
- Accept means pix_valid & pix_ready. On accept:
  - mem[wr_addr] ← encode(pix_color).
  - wr_addr increments.
  - pixel_count increments.
- Encode: an exact match to PALn gives n. If several entries are equal, the lowest n wins.
- Unmatched color (macro off): index 0 is written and err is set.
- start in any state (including LOAD or DONE) restarts the pass:
  - wr_addr=0, pixel_count=0, err=0, state=LOAD.
  - A pixel presented in the same cycle as start is not accepted. pix_ready for that cycle reflects the pre-start state, but the write is suppressed.
- pix_valid in IDLE or DONE is ignored; nothing is written.
- Read port:
  - output_color ← PAL[mem[read_address]] each cycle.
  - read_address ≥ DEPTH returns PAL0.
- Simultaneous write and read of the same address returns the old data (read-before-write).
- Memory contents are not cleared by Reset or start.

## Timing
- Reset values:
  - state=IDLE, wr_addr=0, pixel_count=0.
  - pix_ready=0, busy=0, done=0, err=0, output_color=0.
- pix_ready and busy rise the cycle after start is sampled.
- Throughput: one pixel per cycle while pix_valid stays high. A full pass takes DEPTH cycles.
- done pulses exactly one cycle, the cycle after the last accept. pixel_count=DEPTH during that cycle and holds until the next start.
- err is set the cycle after the offending accept. It holds until start or Reset.
- Read latency is 1 cycle from read_address to output_color. Reads are not gated by FSM state.
- Reset mid-LOAD aborts the pass. Pixels already written remain in memory.

## Configuration
- Macro SPRITE_RAM_LOADER_NEAREST_EN.
- Defined: an unmatched color is encoded to the palette entry with the minimum sum of absolute R, G and B differences.
  - Ties go to the lowest index.
  - err is never set.
  - Encode remains single-cycle combinational before the write.
- Undefined: the unmatched color maps to index 0 and err is set, as described in Operation.

## Test plan
- Reset, then start, then 441 consecutive pixels cycling PAL0..PAL3.
  - done pulses once, the cycle after the 441st accept; pixel_count=441; err=0.
  - Reading address 6 returns PAL2 one cycle later.
- Pixel stream with pix_valid toggling every other cycle. 441 accepts take 882 cycles, and the written addresses are contiguous with no gaps.
- Write pixel 24'h123456 at address 10.
  - Macro off: err=1, and reading address 10 returns 24'h800080.
  - Macro on: err=0, and reading address 10 returns 24'h202020.
- start asserted after 100 accepts: pixel_count returns to 0, err clears, and the next pixel lands at address 0.
- Reset asserted mid-LOAD at address 200: the block goes to IDLE with pix_ready=0; reading address 199 still returns its written color.
- read_address=500 returns 24'h800080. Writing and reading address 5 in the same cycle returns the prior color, and the new color appears on the next read.

Source files
------------

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: writable 21x21 sprite store.
// Incoming 24-bit RGB pixels are encoded to a 2-bit palette index and written
// sequentially. A registered read port decodes indices back to 24-bit color.
// Optional feature macro: SPRITE_RAM_LOADER_NEAREST_EN. When it is defined,
// unmatched colors are mapped to the nearest palette entry by L1 RGB distance
// and err is never raised. Otherwise they are mapped to index 0 and err is set.
module sprite_ram_loader #(
    parameter int unsigned DEPTH  = 441,
    parameter int unsigned ADDR_W = 9,
    parameter logic [23:0] PAL0   = 24'h800080,
    parameter logic [23:0] PAL1   = 24'h202020,
    parameter logic [23:0] PAL2   = 24'hE45810,
    parameter logic [23:0] PAL3   = 24'hF4D4B4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_color,
    output logic              pix_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pixel_count,
    input  logic [ADDR_W-1:0] read_address,
    output logic [23:0]       output_color
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept;
    logic [2:0]        match;
    logic [1:0]        enc_idx;
    logic              enc_miss;
    logic [1:0]        mem [DEPTH];

    function automatic logic [23:0] pal_color(input logic [1:0] idx);
        logic [23:0] c;
        case (idx)
            2'd0:    c = PAL0;
            2'd1:    c = PAL1;
            2'd2:    c = PAL2;
            default: c = PAL3;
        endcase
        return c;
    endfunction

    // Returns {hit, index}; the lowest matching index wins on duplicate entries.
    function automatic logic [2:0] exact_match(input logic [23:0] c);
        logic [2:0] r;
        logic [1:0] idx;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = i[1:0];
            if (!r[2] && (c == pal_color(idx))) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

`ifdef SPRITE_RAM_LOADER_NEAREST_EN
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Minimum sum of absolute channel differences; strict compare keeps ties low.
    function automatic logic [1:0] nearest(input logic [23:0] c);
        logic [9:0]  best_d;
        logic [9:0]  d;
        logic [1:0]  best;
        logic [1:0]  idx;
        logic [23:0] p;
        best_d = '1;
        best   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = i[1:0];
            p   = pal_color(idx);
            d   = {2'b00, abs_diff(c[23:16], p[23:16])}
                + {2'b00, abs_diff(c[15:8],  p[15:8])}
                + {2'b00, abs_diff(c[7:0],   p[7:0])};
            if (d < best_d) begin
                best_d = d;
                best   = idx;
            end
        end
        return best;
    endfunction
`endif

    // Pixel encoder: exact palette match first, fallback for unmatched colors.
    always_comb begin
        match = exact_match(pix_color);
`ifdef SPRITE_RAM_LOADER_NEAREST_EN
        enc_idx  = match[2] ? match[1:0] : nearest(pix_color);
        enc_miss = 1'b0;
`else
        enc_idx  = match[2] ? match[1:0] : 2'd0;
        enc_miss = ~match[2];
`endif
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; start overrides everything and
    // suppresses the write of a pixel presented in the same cycle.
    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
        accept = pix_valid & pix_ready & ~start;
        if (start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (accept && (wr_addr == LAST_ADDR)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Write address / accepted-pixel counter and sticky error flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_addr <= '0;
            err     <= 1'b0;
        end else if (start) begin
            wr_addr <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            wr_addr <= wr_addr + 1'b1;
            if (enc_miss) begin
                err <= 1'b1;
            end
        end
    end

    assign pixel_count = wr_addr;

    // Sprite memory write; contents survive Reset and start.
    always_ff @(posedge Clk) begin
        if (accept && !Reset) begin
            mem[wr_addr] <= enc_idx;
        end
    end

    // Registered decode read port; out-of-range addresses return PAL0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            output_color <= '0;
        end else if ({1'b0, read_address} >= DEPTH_X) begin
            output_color <= PAL0;
        end else begin
            output_color <= pal_color(mem[read_address]);
        end
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: encode vectors from a table,
// then hand-written multi-cycle sequences for pass control and read timing.
module tb_sprite_ram_loader;

    localparam logic [23:0] PAL0 = 24'h800080;
    localparam logic [23:0] PAL1 = 24'h202020;
    localparam logic [23:0] PAL2 = 24'hE45810;
    localparam logic [23:0] PAL3 = 24'hF4D4B4;
    localparam logic [23:0] ODD  = 24'h123456;

`ifdef SPRITE_RAM_LOADER_NEAREST_EN
    localparam logic        EXP_ERR = 1'b0;
    localparam logic [23:0] EXP_ODD = PAL1;
`else
    localparam logic        EXP_ERR = 1'b1;
    localparam logic [23:0] EXP_ODD = PAL0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_color = '0;
    logic        pix_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  pixel_count;
    logic [8:0]  read_address = '0;
    logic [23:0] output_color;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [23:0] color;
        logic [23:0] exp_color;
        logic        exp_err;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    sprite_ram_loader #(
        .DEPTH (441),
        .ADDR_W(9)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .pix_valid   (pix_valid),
        .pix_color   (pix_color),
        .pix_ready   (pix_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pixel_count (pixel_count),
        .read_address(read_address),
        .output_color(output_color)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pal(input int unsigned i);
        case (i % 4)
            0:       return PAL0;
            1:       return PAL1;
            2:       return PAL2;
            default: return PAL3;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned bad;
        int unsigned early_done;
        logic        got;

        // Encode vectors: color written to address 0, then read back.
        vecs[0] = '{PAL0, PAL0, 1'b0};
        vecs[1] = '{PAL1, PAL1, 1'b0};
        vecs[2] = '{PAL2, PAL2, 1'b0};
        vecs[3] = '{PAL3, PAL3, 1'b0};
        vecs[4] = '{ODD,  EXP_ODD, EXP_ERR};
`ifdef SPRITE_RAM_LOADER_NEAREST_EN
        vecs[5] = '{24'h000000, PAL1, 1'b0};
        vecs[6] = '{24'hFFFFFF, PAL3, 1'b0};
        vecs[7] = '{24'h800081, PAL0, 1'b0};
        vecs[8] = '{24'hE45811, PAL2, 1'b0};
`else
        vecs[5] = '{24'h000000, PAL0, 1'b1};
        vecs[6] = '{24'hFFFFFF, PAL0, 1'b1};
        vecs[7] = '{24'h800081, PAL0, 1'b1};
        vecs[8] = '{24'hE45811, PAL0, 1'b1};
`endif

        // Reset state, sampled while Reset is held.
        tick();
        tick();
        check("rst_pix_ready", pix_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", pixel_count, 0);
        check("rst_color", output_color, 0);
        Reset = 1'b0;
        tick();
        check("idle_ready", pix_ready, 0);

        for (int i = 0; i < NV; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            pix_valid = 1'b1;
            pix_color = vecs[i].color;
            tick();
            pix_valid = 1'b0;
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            read_address = 9'd0;
            tick();
            check($sformatf("vec%0d_color", i), output_color, vecs[i].exp_color);
        end

        // Full back-to-back pass cycling PAL0..PAL3.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ready", pix_ready, 1);
        check("load_busy", busy, 1);
        check("load_count0", pixel_count, 0);
        pix_valid = 1'b1;
        early_done = 0;
        for (int unsigned i = 0; i < 441; i++) begin
            pix_color = pal(i);
            tick();
            if (i < 440 && done) early_done++;
        end
        check("early_done", early_done, 0);
        check("done_pulse", done, 1);
        check("full_count", pixel_count, 441);
        check("done_busy", busy, 0);
        check("done_ready", pix_ready, 0);
        check("full_err", err, 0);
        pix_valid = 1'b0;
        read_address = 9'd6;
        tick();
        check("done_one_cycle", done, 0);
        check("count_hold", pixel_count, 441);
        check("rd6", output_color, PAL2);

        // pix_valid toggling every other cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        got = 1'b0;
        for (int unsigned c = 0; c < 2000 && !got; c++) begin
            pix_valid = (c % 2 == 0);
            pix_color = pal(n + 1);
            tick();
            if (pix_valid && n < 441) n++;
            if (done) begin
                got = 1'b1;
                check("toggle_done_cycle", c, 880);
            end
        end
        check("toggle_done_seen", got, 1);
        pix_valid = 1'b0;
        check("toggle_count", pixel_count, 441);
        bad = 0;
        for (int unsigned a = 0; a < 441; a++) begin
            read_address = 9'(a);
            tick();
            if (output_color !== pal(a + 1)) bad++;
        end
        check("toggle_contiguous", bad, 0);

        // Unmatched color at address 10.
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_valid = 1'b1;
        pix_color = PAL3;
        for (int unsigned i = 0; i < 10; i++) tick();
        check("pre_odd_err", err, 0);
        pix_color = ODD;
        tick();
        pix_valid = 1'b0;
        check("odd_err", err, EXP_ERR);
        check("odd_count", pixel_count, 11);
        read_address = 9'd10;
        tick();
        check("rd10", output_color, EXP_ODD);

        // Restart after 100 accepts; the start-cycle pixel must not be written.
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_valid = 1'b1;
        for (int unsigned i = 0; i < 100; i++) begin
            pix_color = (i == 50) ? ODD : PAL1;
            tick();
        end
        check("pre_restart_count", pixel_count, 100);
        check("pre_restart_err", err, EXP_ERR);
        start = 1'b1;
        pix_color = PAL2;
        #1;
        check("restart_cycle_ready", pix_ready, 1);
        tick();
        start = 1'b0;
        check("restart_count", pixel_count, 0);
        check("restart_err", err, 0);
        check("restart_busy", busy, 1);
        pix_color = PAL3;
        tick();
        pix_valid = 1'b0;
        check("restart_count1", pixel_count, 1);
        read_address = 9'd0;
        tick();
        check("restart_rd0", output_color, PAL3);
        read_address = 9'd100;
        tick();
        check("restart_suppressed", output_color, PAL1);
        read_address = 9'd1;
        tick();
        check("restart_rd1", output_color, PAL1);

        // Reset in the middle of a pass at address 200.
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_valid = 1'b1;
        pix_color = PAL2;
        for (int unsigned i = 0; i < 200; i++) tick();
        check("mid_count", pixel_count, 200);
        pix_color = PAL3;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_ready", pix_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_count", pixel_count, 0);
        tick();
        tick();
        check("idle_ignore_count", pixel_count, 0);
        check("idle_ignore_ready", pix_ready, 0);
        pix_valid = 1'b0;
        read_address = 9'd199;
        tick();
        check("abort_rd199", output_color, PAL2);
        read_address = 9'd0;
        tick();
        check("idle_ignore_rd0", output_color, PAL2);

        // Out-of-range read and read-before-write collision.
        read_address = 9'd500;
        tick();
        check("rd500", output_color, PAL0);
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_valid = 1'b1;
        pix_color = PAL0;
        for (int unsigned i = 0; i < 5; i++) tick();
        pix_color = PAL3;
        read_address = 9'd5;
        tick();
        pix_valid = 1'b0;
        check("rw_old", output_color, PAL2);
        tick();
        check("rw_new", output_color, PAL3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
